// File: rtl/onchip_frame_reader.sv
// onchip_frame_reader: Avalon-MM block reader feeding an Avalon-ST pixel stream.
// Optional underflow counter port enabled by `define FRAME_READER_UNDERFLOW_CNT_EN.
module onchip_frame_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 8000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       num_q, num_d;
    logic [15:0]       iss_q, iss_d;
    logic [15:0]       out_q, out_d;
    logic              done_q, done_d;
    logic              infl_q;
    logic              valid_q;
    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              issue, push, pop, last;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign mem_address    = addr_q;
    assign mem_chipselect = issue;

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign st_valid = valid_q;
    assign st_data  = fifo_q[rd_q];
    assign st_sop   = valid_q && (out_q == 16'd0);
    assign st_eop   = valid_q && (out_q == num_q - 16'd1);

    // Credit check: FIFO occupancy plus the read in flight must leave a slot.
    assign issue = (state_q == FETCH)
                && ((cnt_q + CW'(infl_q)) < CW'(FIFO_DEPTH));
    assign push  = infl_q;
    assign pop   = valid_q && st_ready;
    assign last  = pop && st_eop;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        num_d   = num_q;
        iss_d   = iss_q;
        out_d   = out_q + 16'(pop);
        done_d  = last;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    out_d = 16'd0;
                    if (num_words == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                        addr_d  = base_addr % ADDR_W'(MEM_WORDS);
                        num_d   = num_words;
                        iss_d   = 16'd0;
                    end
                end
            end
            FETCH: begin
                if (issue) begin
                    addr_d = (addr_q == ADDR_W'(MEM_WORDS - 1))
                           ? '0 : addr_q + ADDR_W'(1);
                    iss_d  = iss_q + 16'd1;
                    if (iss_q + 16'd1 == num_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            num_q   <= '0;
            iss_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
            iss_q   <= iss_d;
            out_q   <= out_d;
            done_q  <= done_d;
            infl_q  <= issue;
        end
    end

    // Output FIFO; read data is captured unconditionally the cycle after an issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= mem_readdata;
                wr_q         <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
        end
    end

`ifdef FRAME_READER_UNDERFLOW_CNT_EN
    logic [15:0] uf_q;

    // Saturating count of cycles the sink was ready but no word was available.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uf_q <= '0;
        end else if (state_q == IDLE && start) begin
            uf_q <= '0;
        end else if (busy && st_ready && !valid_q && uf_q != 16'hFFFF) begin
            uf_q <= uf_q + 16'd1;
        end
    end

    assign underflow_cnt = uf_q;
`endif

endmodule

// File: tb/tb_onchip_frame_reader.sv
// tb_onchip_frame_reader: randomized stream checks against an address/word model.
// Underflow counter checks compile only with FRAME_READER_UNDERFLOW_CNT_EN.
module tb_onchip_frame_reader;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int MW = 8000;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   num_words = '0;
    logic          busy, done;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [3:0]    mem_byteenable;
    logic [DW-1:0] mem_readdata = '0;
    logic [DW-1:0] st_data;
    logic          st_valid, st_sop, st_eop;
    logic          st_ready = 1'b0;
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
    logic [15:0]   underflow_cnt;
`endif

    logic [DW-1:0] mem [MW];
    int total = 0;
    int bad = 0;

    onchip_frame_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop)
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt  (underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered address, read latency 1.
    always @(posedge clk) begin
        if (int'(mem_address) < MW) mem_readdata <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rdy(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            default: return ($urandom_range(0, 3) == 0);
        endcase
    endfunction

    task automatic run_xfer(input logic [AW-1:0] base, input logic [15:0] num,
                            input int mode, input bit poke);
        int exp_addr[$];
        logic [DW+1:0] got[$];
        int iss[$];
        logic [DW+1:0] prev;
        logic [DW+1:0] expw;
        bit pv;
        int cyc, first_v, eop_cyc, done_cyc, done_n;
        int outst, cviol, sviol, post_v, b0;
        logic busy_at_done;
        b0 = int'(base) % MW;
        for (int k = 0; k < int'(num); k++) exp_addr.push_back((b0 + k) % MW);
        first_v = -1; eop_cyc = -1; done_cyc = -1; done_n = 0;
        outst = 0; cviol = 0; sviol = 0; post_v = 0; pv = 0;
        prev = '0; busy_at_done = 1'b1;
        @(posedge clk); #1;
        base_addr = base;
        num_words = num;
        start = 1'b1;
        st_ready = rdy(mode, 0);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (mem_chipselect) begin
                if (outst >= FD) cviol++;
                outst++;
                iss.push_back(int'(mem_address));
            end
            if (st_valid) begin
                if (first_v < 0) first_v = cyc;
                if (pv && prev !== {st_data, st_sop, st_eop}) sviol++;
                if (done_cyc >= 0) post_v++;
                if (st_ready) begin
                    got.push_back({st_data, st_sop, st_eop});
                    outst--;
                    if (st_eop) eop_cyc = cyc;
                end
            end
            pv = st_valid && !st_ready;
            prev = {st_data, st_sop, st_eop};
            if (done) begin
                done_n++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            if (cyc >= 1500) break;
            @(posedge clk); #1;
            cyc++;
            start = poke && (cyc == 4);
            if (poke) begin
                base_addr = base + 13'd100;
                num_words = num + 16'd5;
            end
            st_ready = rdy(mode, cyc);
        end
        start = 1'b0;
        chk("done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("done_count", 64'(done_n), 64'd1);
        chk("busy_at_done", 64'(busy_at_done), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        if (num == 16'd0) begin
            chk("zero_done_lat", 64'(done_cyc), 64'd1);
            chk("zero_no_valid", 64'(first_v < 0), 64'd1);
            chk("zero_no_issue", 64'(iss.size()), 64'd0);
        end else begin
            chk("first_valid", 64'(first_v), 64'd3);
            chk("done_after_eop", 64'(done_cyc - eop_cyc), 64'd1);
            chk("nwords", 64'(got.size()), 64'(num));
            chk("nissue", 64'(iss.size()), 64'(num));
            for (int k = 0; k < got.size() && k < int'(num); k++) begin
                expw = {mem[exp_addr[k]], k == 0, k == int'(num) - 1};
                chk($sformatf("word%0d", k), 64'(got[k]), 64'(expw));
            end
            for (int k = 0; k < iss.size() && k < int'(num); k++)
                chk($sformatf("addr%0d", k), 64'(iss[k]), 64'(exp_addr[k]));
            chk("credit", 64'(cviol), 64'd0);
            chk("stall_stable", 64'(sviol), 64'd0);
            chk("valid_after_done", 64'(post_v), 64'd0);
            if (mode == 0)
                chk("throughput", 64'(eop_cyc), 64'(2 + int'(num)));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_outs"},
            64'({st_valid, st_sop, st_eop, mem_chipselect}), 64'd0);
        chk({tag, "_addr"}, 64'(mem_address), 64'd0);
        chk({tag, "_data"}, 64'(st_data), 64'd0);
    endtask

    task automatic reset_mid();
        int n, c, dn;
        n = 0; c = 0; dn = 0;
        @(posedge clk); #1;
        base_addr = 13'd50;
        num_words = 16'd10;
        start = 1'b1;
        st_ready = 1'b1;
        while (n < 3 && c < 100) begin
            @(negedge clk);
            if (st_valid && st_ready) n++;
            if (n < 3) begin
                @(posedge clk); #1;
                start = 1'b0;
                c++;
            end
        end
        chk("mid_reached", 64'(n), 64'd3);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || busy || st_valid) dn++;
        end
        chk("midrst_quiet", 64'(dn), 64'd0);
        run_xfer(13'd70, 16'd2, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < MW; i++) mem[i] = $urandom();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        chk("consts", 64'({mem_write, mem_byteenable, mem_clken}), 64'h1F);
        reset_n = 1'b1;

        run_xfer(13'h010, 16'd4, 0, 1'b0);
        run_xfer(13'd100, 16'd20, 1, 1'b1);
        run_xfer(13'd7998, 16'd4, 0, 1'b0);
        run_xfer(13'd300, 16'd0, 0, 1'b0);
        run_xfer(13'd301, 16'd1, 0, 1'b0);
        run_xfer(13'd8100, 16'd6, 2, 1'b0);
        run_xfer(13'd500, 16'd30, 2, 1'b0);
        reset_mid();
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
        run_xfer(13'd5, 16'd3, 0, 1'b0);
        chk("underflow", 64'(underflow_cnt), 64'd2);
`endif
        repeat (6) begin
            run_xfer(AW'($urandom_range(0, 8191)), 16'($urandom_range(1, 40)),
                     int'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
